vga_layer_compositor: RTL and testbench
=======================================

# vga_layer_compositor

Parametrised pixel compositor between the per-layer pixel sources (map, robot icons, title overlay) and the VGA pins. It merges NUM_LAYERS colour layers over a palette-driven background by fixed priority with colour-key transparency. Layer enables, blink mask and mode are latched at the vertical-sync boundary, so changes never tear mid-frame. It adds a per-layer blink function and a two-stage pipeline with sync signals delayed to match.

## Interface
- NUM_LAYERS, 4: overlay layer count, 1..8; layer 0 has the highest priority.
- COLOR_W, 12: pixel width, RGB 4:4:4; must be a multiple of 3.
- KEY_COLOR, 12'h000: transparent colour value for every layer.
- BLINK_FRAMES, 30: frames per blink half-period, >=1.
- BG_COLOR0..BG_COLOR3, 12'hFFF / 12'h000 / 12'h840 / 12'h0F0: background palette.
- clk  in  1  pixel clock.
- reset_n  in  1  synchronous, active-low reset.
- layer_pix  in  NUM_LAYERS*COLOR_W  layer i occupies bits [i*COLOR_W +: COLOR_W].
- bg_sel  in  2  background palette index for the current pixel (world map code).
- layer_en  in  NUM_LAYERS  requested layer enables (typically switches).
- blink_mask  in  NUM_LAYERS  requested blink enables.
- mode  in  2  00 composite; 01 composite, background forced black; 10 background only; 11 blank (all zero).
- video_on  in  1  active-video flag aligned with the pixel inputs.
- hsync_in, vsync_in  in  1  active-low syncs aligned with the pixel inputs.
- vga_r, vga_g, vga_b  out  COLOR_W/3 each  registered colour.
- hsync_out, vsync_out  out  1  syncs delayed to match the colour path.
- frame_tick  out  1  one-cycle pulse when the shadow registers update.

## Operation
- Stage 1 registers layer_pix, bg_sel, video_on, hsync_in and vsync_in.
- Frame boundary: the stage-1 vsync goes 1->0 (a registered previous value is kept for edge detection).
  - In the cycle after detection, the shadow registers en_s, blink_s and mode_s load layer_en, blink_mask and mode.
  - In that same cycle, frame_tick=1.
  - In that same cycle, the blink frame counter advances.
- Blink counter:
  - Counts 0..BLINK_FRAMES-1.
  - On wrap to 0, blink_phase toggles.
  - With BLINK_FRAMES=1, blink_phase toggles every frame.
- Layer i is visible when all of the following hold:
  - en_s[i]=1;
  - the pixel != KEY_COLOR;
  - NOT (blink_s[i] AND blink_phase).
- Stage 2 output selection:
  - If video_on is 0, output zero.
  - mode_s=11: output zero.
  - mode_s=10: output BG_COLOR[bg_sel].
  - Otherwise: the lowest-index visible layer; if no layer is visible, the background. The background is BG_COLOR[bg_sel] in mode 00 and 0 in mode 01.
- Priority is strict. Two visible layers on one pixel always yield the lower index.
- Mode and enable changes between frame boundaries have no effect until the next boundary.

## Timing
- Latency is 2 clk from inputs to vga_*/hsync_out/vsync_out. The syncs and colour for one pixel leave in the same cycle.
- Reset (reset_n=0 at a clk edge):
  - vga_r/g/b = 0.
  - hsync_out = vsync_out = 1 (inactive).
  - frame_tick = 0.
  - Both pipeline stages are cleared to blank/inactive.
  - en_s = all ones, blink_s = 0, mode_s = 00.
  - Frame counter = 0, blink_phase = 0.
  - The edge-detect register = 1, so no false boundary is detected on release.
- Reset asserted mid-frame takes effect on the next edge and overrides a same-cycle frame boundary. Output resumes 2 clk after release.
- frame_tick follows the stage-1 vsync falling edge by exactly 1 clk, i.e. 2 clk after the vsync_in falling edge at the pins.
- New shadow values govern pixels that enter stage 2 on or after the frame_tick cycle.
- vsync held low for many cycles produces only one boundary.

## Test plan
- Priority/key: layer0=12'h000, layer1=12'h0F0, layer2=12'hF00, all enabled, mode 00, video_on=1 -> output 12'h0F0 two clk later. Then layer0=12'h00F -> output 12'h00F.
- Background: all layers 12'h000, bg_sel=2 -> 12'h840. mode 01 -> 12'h000. mode 10 with layer0=12'hFFF, bg_sel=0 -> 12'hFFF.
- Frame latch: change layer_en to 4'b1110 mid-frame -> output unchanged until frame_tick. Then layer1 is shown where layer0 was. frame_tick is exactly 2 clk after the vsync_in fall.
- Blink: BLINK_FRAMES=2, blink_mask[0]=1, layer0=12'hF00 -> layer0 visible frames 0-1, hidden frames 2-3, visible frames 4-5.
- Blanking/sync: video_on=0 -> output 0 regardless of layers. hsync/vsync pulses are reproduced with 2-clk delay and identical width.
- Reset: assert reset_n=0 mid-frame coincident with a vsync fall -> next cycle outputs 0, syncs=1, frame_tick=0. After release, en_s=all ones, mode 00, blink_phase=0.

Source files
------------

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : vga_layer_compositor
// Purpose  : Priority/colour-key compositor of overlay layers over a palette
//            background, with frame-latched controls, blink, 2-stage pipeline.
// Revision : 1.0
// ============================================================================
module vga_layer_compositor #(
    parameter int                 NUM_LAYERS   = 4,
    parameter int                 COLOR_W      = 12,
    parameter logic [COLOR_W-1:0] KEY_COLOR    = 12'h000,
    parameter int                 BLINK_FRAMES = 30,
    parameter logic [COLOR_W-1:0] BG_COLOR0    = 12'hFFF,
    parameter logic [COLOR_W-1:0] BG_COLOR1    = 12'h000,
    parameter logic [COLOR_W-1:0] BG_COLOR2    = 12'h840,
    parameter logic [COLOR_W-1:0] BG_COLOR3    = 12'h0F0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_LAYERS*COLOR_W-1:0]  layer_pix,
    input  logic [1:0]                     bg_sel,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS-1:0]          blink_mask,
    input  logic [1:0]                     mode,
    input  logic                           video_on,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    output logic [COLOR_W/3-1:0]           vga_r,
    output logic [COLOR_W/3-1:0]           vga_g,
    output logic [COLOR_W/3-1:0]           vga_b,
    output logic                           hsync_out,
    output logic                           vsync_out,
    output logic                           frame_tick
);

    localparam int              c_CH_W     = COLOR_W / 3;
    localparam int              c_CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_FRAMES - 1);
    localparam logic [1:0]      c_MODE_COMP  = 2'b00;
    localparam logic [1:0]      c_MODE_BG    = 2'b10;
    localparam logic [1:0]      c_MODE_BLANK = 2'b11;

    // Stage 1
    logic [NUM_LAYERS*COLOR_W-1:0] r_pix1;
    logic [1:0]                    r_bg1;
    logic                          r_von1;
    logic                          r_hs1;
    logic                          r_vs1;

    // Frame-boundary shadow state
    logic                    r_vs_prev;
    logic [NUM_LAYERS-1:0]   r_en_s;
    logic [NUM_LAYERS-1:0]   r_blink_s;
    logic [1:0]              r_mode_s;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_phase;
    logic                    r_frame_tick;

    // Stage 2
    logic [COLOR_W-1:0]      r_color;
    logic                    r_hs2;
    logic                    r_vs2;

    logic                    w_frame;
    logic [NUM_LAYERS-1:0]   w_vis;
    logic                    w_hit;
    logic [COLOR_W-1:0]      w_layer_pix;
    logic [COLOR_W-1:0]      w_bg;
    logic [COLOR_W-1:0]      w_color;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pix1 <= '0;
            r_bg1  <= '0;
            r_von1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
        end else begin
            r_pix1 <= layer_pix;
            r_bg1  <= bg_sel;
            r_von1 <= video_on;
            r_hs1  <= hsync_in;
            r_vs1  <= vsync_in;
        end
    end

    assign w_frame = r_vs_prev & ~r_vs1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vs_prev    <= 1'b1;
            r_en_s       <= '1;
            r_blink_s    <= '0;
            r_mode_s     <= c_MODE_COMP;
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_prev    <= r_vs1;
            r_frame_tick <= w_frame;
            if (w_frame) begin
                r_en_s    <= layer_en;
                r_blink_s <= blink_mask;
                r_mode_s  <= mode;
                if (r_cnt == c_CNT_MAX) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_vis
            assign w_vis[gi] = r_en_s[gi]
                            && (r_pix1[gi*COLOR_W +: COLOR_W] != KEY_COLOR)
                            && !(r_blink_s[gi] && r_phase);
        end
    endgenerate

    always_comb begin
        case (r_bg1)
            2'd0:    w_bg = BG_COLOR0;
            2'd1:    w_bg = BG_COLOR1;
            2'd2:    w_bg = BG_COLOR2;
            default: w_bg = BG_COLOR3;
        endcase
    end

    // Scan from the lowest priority upward so layer 0 is the last writer.
    always_comb begin
        w_hit       = 1'b0;
        w_layer_pix = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_vis[i]) begin
                w_hit       = 1'b1;
                w_layer_pix = r_pix1[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        w_color = '0;
        if (r_von1) begin
            case (r_mode_s)
                c_MODE_BLANK: w_color = '0;
                c_MODE_BG:    w_color = w_bg;
                default: begin
                    if (w_hit)
                        w_color = w_layer_pix;
                    else if (r_mode_s == c_MODE_COMP)
                        w_color = w_bg;
                    else
                        w_color = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_color <= '0;
            r_hs2   <= 1'b1;
            r_vs2   <= 1'b1;
        end else begin
            r_color <= w_color;
            r_hs2   <= r_hs1;
            r_vs2   <= r_vs1;
        end
    end

    assign vga_r      = r_color[COLOR_W-1 -: c_CH_W];
    assign vga_g      = r_color[2*c_CH_W-1 -: c_CH_W];
    assign vga_b      = r_color[c_CH_W-1:0];
    assign hsync_out  = r_hs2;
    assign vsync_out  = r_vs2;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_layer_compositor
// Purpose  : Directed self-checking bench for vga_layer_compositor.
// Revision : 1.0
// ============================================================================
module tb_vga_layer_compositor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [47:0] layer_pix;
    logic [1:0]  bg_sel;
    logic [3:0]  layer_en;
    logic [3:0]  blink_mask;
    logic [1:0]  mode;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync_out;
    logic        vsync_out;
    logic        frame_tick;
    logic [11:0] w_out;

    int n_pass  = 0;
    int n_total = 0;

    assign w_out = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    vga_layer_compositor #(
        .NUM_LAYERS   (4),
        .COLOR_W      (12),
        .KEY_COLOR    (12'h000),
        .BLINK_FRAMES (2),
        .BG_COLOR0    (12'hFFF),
        .BG_COLOR1    (12'h000),
        .BG_COLOR2    (12'h840),
        .BG_COLOR3    (12'h0F0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .layer_pix  (layer_pix),
        .bg_sel     (bg_sel),
        .layer_en   (layer_en),
        .blink_mask (blink_mask),
        .mode       (mode),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick)
    );

    task automatic set_pix(input logic [11:0] l0, input logic [11:0] l1,
                           input logic [11:0] l2, input logic [11:0] l3);
        layer_pix = {l3, l2, l1, l0};
    endtask

    // One vsync pulse; shadow registers pick up whatever controls are driven.
    task automatic frame_boundary();
        @(negedge clk);
        vsync_in = 1'b0;
        repeat (4) @(negedge clk);
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        set_pix(12'h123, 12'h456, 12'h789, 12'hABC);
        bg_sel     = 2'd0;
        layer_en   = 4'hF;
        blink_mask = 4'h0;
        mode       = 2'b00;
        video_on   = 1'b1;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (w_out !== 12'h000) $display("FAIL reset_color got %h exp 000", w_out);
        else n_pass++;
        n_total++;
        if ({hsync_out, vsync_out} !== 2'b11) $display("FAIL reset_syncs got %b exp 11", {hsync_out, vsync_out});
        else n_pass++;
        n_total++;
        if (frame_tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", frame_tick);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        set_pix(12'h000, 12'h0F0, 12'hF00, 12'h000);
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h0F0) $display("FAIL prio_key got %h exp 0F0", w_out);
        else n_pass++;
        set_pix(12'h00F, 12'h0F0, 12'hF00, 12'h000);
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h00F) $display("FAIL prio_layer0 got %h exp 00F", w_out);
        else n_pass++;
    endtask

    task automatic test_background();
        set_pix(12'h000, 12'h000, 12'h000, 12'h000);
        bg_sel = 2'd2;
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h840) $display("FAIL bg_sel2 got %h exp 840", w_out);
        else n_pass++;
        bg_sel = 2'd3;
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h0F0) $display("FAIL bg_sel3 got %h exp 0F0", w_out);
        else n_pass++;
        mode = 2'b01;
        repeat (3) @(negedge clk);
        n_total++;
        if (w_out !== 12'h0F0) $display("FAIL mode_midframe got %h exp 0F0", w_out);
        else n_pass++;
        frame_boundary();
        n_total++;
        if (w_out !== 12'h000) $display("FAIL mode01_black got %h exp 000", w_out);
        else n_pass++;
        mode = 2'b10;
        frame_boundary();
        set_pix(12'hFFF, 12'h000, 12'h000, 12'h000);
        bg_sel = 2'd0;
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'hFFF) $display("FAIL mode10_bg got %h exp FFF", w_out);
        else n_pass++;
        set_pix(12'h00F, 12'h000, 12'h000, 12'h000);
        bg_sel = 2'd2;
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h840) $display("FAIL mode10_ignore_layer got %h exp 840", w_out);
        else n_pass++;
        mode = 2'b11;
        frame_boundary();
        n_total++;
        if (w_out !== 12'h000) $display("FAIL mode11_blank got %h exp 000", w_out);
        else n_pass++;
        mode = 2'b00;
        frame_boundary();
    endtask

    task automatic test_frame_latch();
        int ticks;
        set_pix(12'h00F, 12'h0F0, 12'h000, 12'h000);
        layer_en = 4'hF;
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h00F) $display("FAIL latch_before got %h exp 00F", w_out);
        else n_pass++;
        layer_en = 4'b1110;
        repeat (3) @(negedge clk);
        n_total++;
        if (w_out !== 12'h00F) $display("FAIL latch_midframe got %h exp 00F", w_out);
        else n_pass++;
        vsync_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (frame_tick !== 1'b0) $display("FAIL tick_early got %b exp 0", frame_tick);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (frame_tick !== 1'b1) $display("FAIL tick_at2 got %b exp 1", frame_tick);
        else n_pass++;
        n_total++;
        if (vsync_out !== 1'b0) $display("FAIL vsync_delay got %b exp 0", vsync_out);
        else n_pass++;
        n_total++;
        if (w_out !== 12'h00F) $display("FAIL latch_tickcycle got %h exp 00F", w_out);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (w_out !== 12'h0F0) $display("FAIL latch_after got %h exp 0F0", w_out);
        else n_pass++;
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            if (frame_tick === 1'b1) ticks++;
            @(negedge clk);
        end
        n_total++;
        if (ticks !== 0) $display("FAIL single_boundary got %0d extra ticks exp 0", ticks);
        else n_pass++;
        vsync_in = 1'b1;
        layer_en = 4'hF;
        frame_boundary();
    endtask

    task automatic test_blink();
        logic [11:0] exp_tab [0:5];
        exp_tab = '{12'hF00, 12'hF00, 12'h0F0, 12'h0F0, 12'hF00, 12'hF00};
        reset_n = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        blink_mask = 4'b0001;
        layer_en   = 4'hF;
        mode       = 2'b00;
        set_pix(12'hF00, 12'h0F0, 12'h000, 12'h000);
        repeat (2) @(negedge clk);
        for (int f = 0; f < 6; f++) begin
            if (f > 0) frame_boundary();
            n_total++;
            if (w_out !== exp_tab[f]) $display("FAIL blink_frame%0d got %h exp %h", f, w_out, exp_tab[f]);
            else n_pass++;
        end
        blink_mask = 4'h0;
    endtask

    task automatic test_blanking_sync();
        logic [11:0] hpat;
        logic [11:0] vpat;
        hpat = 12'b111100011111;
        vpat = 12'b111110011111;
        set_pix(12'hF00, 12'h0F0, 12'h00F, 12'hFFF);
        video_on = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h000) $display("FAIL video_off got %h exp 000", w_out);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            hsync_in = hpat[k];
            vsync_in = vpat[k];
            @(negedge clk);
            if (k >= 1) begin
                n_total++;
                if (hsync_out !== hpat[k-1] || vsync_out !== vpat[k-1])
                    $display("FAIL sync_delay_%0d got %b%b exp %b%b", k, hsync_out, vsync_out, hpat[k-1], vpat[k-1]);
                else n_pass++;
            end
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        video_on = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        layer_en = 4'b1110;
        mode     = 2'b01;
        set_pix(12'h00F, 12'h0F0, 12'h000, 12'h000);
        bg_sel   = 2'd2;
        frame_boundary();
        n_total++;
        if (w_out !== 12'h0F0) $display("FAIL rst_setup got %h exp 0F0", w_out);
        else n_pass++;
        vsync_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (w_out !== 12'h000) $display("FAIL rst_mid_color got %h exp 000", w_out);
        else n_pass++;
        n_total++;
        if ({hsync_out, vsync_out} !== 2'b11) $display("FAIL rst_mid_syncs got %b exp 11", {hsync_out, vsync_out});
        else n_pass++;
        n_total++;
        if (frame_tick !== 1'b0) $display("FAIL rst_mid_tick got %b exp 0", frame_tick);
        else n_pass++;
        reset_n  = 1'b1;
        vsync_in = 1'b1;
        @(negedge clk);
        n_total++;
        if (w_out !== 12'h000 || frame_tick !== 1'b0) $display("FAIL rst_release1 got %h/%b exp 000/0", w_out, frame_tick);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (w_out !== 12'h00F) $display("FAIL rst_en_default got %h exp 00F", w_out);
        else n_pass++;
        set_pix(12'h000, 12'h000, 12'h000, 12'h000);
        repeat (2) @(negedge clk);
        n_total++;
        if (w_out !== 12'h840) $display("FAIL rst_mode_default got %h exp 840", w_out);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_priority();
        test_background();
        test_frame_latch();
        test_blink();
        test_blanking_sync();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
